// File: rtl/k2_pkg.sv
// Shared definitions for the K2 sequencer: instruction field widths,
// opcode encodings and the control FSM state type.
package k2_pkg;

   localparam int PC_W   = 4;
   localparam int INST_W = 8;

   // Opcode lives in ir[7:6]; jump target lives in ir[3:0].
   localparam logic [1:0] OP_ALU = 2'b00;
   localparam logic [1:0] OP_JC  = 2'b01;
   localparam logic [1:0] OP_J   = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      EXEC  = 2'b10,
      HALT  = 2'b11
   } k2_state_e;

   function automatic logic [1:0] op_of(input logic [INST_W-1:0] inst);
      return inst[7:6];
   endfunction

endpackage

// File: rtl/k2_next_pc.sv
// Combinational next-PC logic: resolves J / JC, and flags a J whose target
// is the current pc (the program's way of asking to stop).
module k2_next_pc
   import k2_pkg::*;
(
   input  logic [INST_W-1:0] ir,
   input  logic [PC_W-1:0]   pc,
   input  logic              carry,
   output logic [PC_W-1:0]   next_pc,
   output logic              taken,
   output logic              self_loop
);

   logic [1:0]      op;
   logic [PC_W-1:0] target;

   // Decode the opcode and pick between the jump target and pc+1 (wraps 15->0).
   always_comb begin
      op        = op_of(ir);
      target    = ir[PC_W-1:0];
      taken     = (op == OP_J) || ((op == OP_JC) && carry);
      next_pc   = taken ? target : (pc + PC_W'(1));
      self_loop = (op == OP_J) && (target == pc);
   end

endmodule

// File: rtl/k2_sequencer.sv
// K2 instruction sequencer: two-cycle FETCH/EXEC loop driven by run/step,
// with a terminal HALT state entered on a jump-to-self.
module k2_sequencer
   import k2_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   input  logic [INST_W-1:0] inst,
   input  logic              carry,
   output logic [PC_W-1:0]   pc,
   output logic [INST_W-1:0] ir,
   output logic              exec_en,
   output logic              jump_taken,
   output logic              illegal,
   output logic              halted,
   output logic [7:0]        retired
);

   k2_state_e         state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0] ir_q, ir_d;
   logic [7:0]        retired_q, retired_d;

   logic [PC_W-1:0]   np_next_pc;
   logic              np_taken;
   logic              np_self_loop;

   k2_next_pc u_next_pc (
      .ir        (ir_q),
      .pc        (pc_q),
      .carry     (carry),
      .next_pc   (np_next_pc),
      .taken     (np_taken),
      .self_loop (np_self_loop)
   );

   // State, pc, ir and retired counter registers with async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   // Next-state logic; pc only moves at the end of EXEC, ir only loads in FETCH.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         IDLE: begin
            if (run || step) state_d = FETCH;
         end
         FETCH: begin
            ir_d    = inst;
            state_d = EXEC;
         end
         EXEC: begin
            pc_d = np_next_pc;
            if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;
            if (np_self_loop)  state_d = HALT;
            else if (run)      state_d = FETCH;
            else               state_d = IDLE;
         end
         HALT: begin
            state_d = HALT;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output strobes decode registered state only (no path from run/step).
   always_comb begin
      exec_en    = (state_q == EXEC);
      jump_taken = exec_en && np_taken;
      illegal    = exec_en && (op_of(ir_q) == OP_ILL);
      halted     = (state_q == HALT);
      pc         = pc_q;
      ir         = ir_q;
      retired    = retired_q;
   end

endmodule

// File: tb/tb_k2_sequencer.sv
// Directed bench for k2_sequencer: drivers push expected exec records,
// a negedge monitor pops and compares on every exec_en.
module tb_k2_sequencer;

   localparam int EXP_W = 14;   // {pc[3:0], ir[7:0], jump_taken, illegal}

   logic       clk = 1'b0;
   logic       rst, run, step, carry;
   logic [7:0] inst;
   logic [3:0] pc;
   logic [7:0] ir;
   logic       exec_en, jump_taken, illegal, halted;
   logic [7:0] retired;

   logic [7:0]       rom [16];
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] mon_e;
   int               n_tests = 0;
   int               n_fail  = 0;
   int               exp_ret = 0;

   k2_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .step       (step),
      .inst       (inst),
      .carry      (carry),
      .pc         (pc),
      .ir         (ir),
      .exec_en    (exec_en),
      .jump_taken (jump_taken),
      .illegal    (illegal),
      .halted     (halted),
      .retired    (retired)
   );

   // ---------------- clock / ROM ----------------
   always #5 clk = ~clk;
   assign inst = rom[pc];

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] p, input logic [7:0] i, input logic jt, input logic il);
      exp_q.push_back({p, i, jt, il});
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         exp_ret = 0;
      end else if (exec_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_exec: pc=%0h ir=%0h, expected no exec_en", pc, ir);
         end else begin
            mon_e = exp_q.pop_front();
            check("exec_pc", 32'(pc), 32'(mon_e[13:10]));
            check("exec_ir", 32'(ir), 32'(mon_e[9:2]));
            check("jump_taken", 32'(jump_taken), 32'(mon_e[1]));
            check("illegal", 32'(illegal), 32'(mon_e[0]));
            check("retired_before_commit", 32'(retired), 32'(exp_ret));
         end
         if (exp_ret < 255) exp_ret++;
      end else begin
         check("no_stray_pulse", {30'd0, jump_taken, illegal}, 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic rom_alu();
      for (int i = 0; i < 16; i++) rom[i] = 8'h20 + 8'(i);
   endtask

   task automatic do_reset();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      rst = 1'b1; run = 1'b0; step = 1'b0; carry = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      rst = 1'b0;
   endtask

   // One step pulse from IDLE; returns with the FSM back in IDLE.
   task automatic step_one();
      step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic push_alu_range(input int first, input int last);
      for (int i = first; i <= last; i++) push(4'(i), rom[i], 1'b0, 1'b0);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      bit found;
      rst = 1'b1; run = 1'b0; step = 1'b0; carry = 1'b0;
      rom_alu();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_ir", 32'(ir), 32'd0);
      check("rst_exec_en", 32'(exec_en), 32'd0);
      check("rst_jump_taken", 32'(jump_taken), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      rst = 1'b0;

      // Idle with run=0/step=0 must not fetch.
      repeat (4) @(posedge clk);
      #1;
      check("idle_hold_pc", 32'(pc), 32'd0);
      check("idle_hold_ir", 32'(ir), 32'd0);

      // Free run over all 16 addresses and wrap back to 0.
      push_alu_range(0, 15);
      push(4'd0, rom[0], 1'b0, 1'b0);
      run = 1'b1;
      repeat (33) @(posedge clk);
      #1;
      check("retired_after_16", 32'(retired), 32'd16);
      run = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("freerun_end_pc", 32'(pc), 32'd1);
      check("freerun_end_retired", 32'(retired), 32'd17);

      // JC 0 at pc=4 with carry=1: taken.
      do_reset();
      rom_alu(); rom[4] = 8'h70;
      carry = 1'b1;
      push_alu_range(0, 3);
      push(4'd4, 8'h70, 1'b1, 1'b0);
      repeat (5) step_one();
      check("jc_taken_pc", 32'(pc), 32'd0);

      // JC 0 at pc=4 with carry=0: falls through.
      do_reset();
      push_alu_range(0, 3);
      push(4'd4, 8'h70, 1'b0, 1'b0);
      repeat (5) step_one();
      check("jc_not_taken_pc", 32'(pc), 32'd5);

      // J 2 at pc=8.
      do_reset();
      rom_alu(); rom[8] = 8'hB2;
      push_alu_range(0, 7);
      push(4'd8, 8'hB2, 1'b1, 1'b0);
      repeat (9) step_one();
      check("j_target_pc", 32'(pc), 32'd2);

      // J 5 at pc=5 halts; run and step are then ignored.
      do_reset();
      rom_alu(); rom[5] = 8'hB5;
      push_alu_range(0, 4);
      push(4'd5, 8'hB5, 1'b1, 1'b0);
      run = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (halted) break;
      end
      check("halt_reached", 32'(halted), 32'd1);
      for (int c = 0; c < 20; c++) begin
         step = (c % 3 == 0);
         @(posedge clk); #1;
         check("halt_pc_hold", 32'(pc), 32'd5);
         check("halt_ir_hold", 32'(ir), 32'hB5);
         check("halt_stays", 32'(halted), 32'd1);
      end
      run = 1'b0; step = 1'b0;

      // Step held into FETCH counts once.
      do_reset();
      rom_alu();
      push(4'd0, rom[0], 1'b0, 1'b0);
      step = 1'b1;
      @(posedge clk); #1;          // now in FETCH, step still high
      @(posedge clk); #1 step = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("step_once_pc", 32'(pc), 32'd1);
      check("step_once_idle", 32'(exec_en), 32'd0);

      // run+step together, run dropped during FETCH: one instruction.
      push(4'd1, rom[1], 1'b0, 1'b0);
      run = 1'b1; step = 1'b1;
      @(posedge clk); #1 run = 1'b0; step = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("run_drop_pc", 32'(pc), 32'd2);

      // Illegal opcode executes as NOP.
      do_reset();
      rom_alu(); rom[0] = 8'hC3;
      push(4'd0, 8'hC3, 1'b0, 1'b1);
      step_one();
      check("illegal_pc", 32'(pc), 32'd1);
      check("illegal_retired", 32'(retired), 32'd1);

      // 300 instructions saturate retired.
      do_reset();
      rom_alu();
      for (int n = 0; n < 300; n++) push(4'(n % 16), rom[n % 16], 1'b0, 1'b0);
      run = 1'b1;
      repeat (600) @(posedge clk);
      #1 run = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("retired_saturated", 32'(retired), 32'd255);
      check("sat_end_pc", 32'(pc), 32'd12);

      // Async reset in the middle of EXEC at pc=7.
      do_reset();
      rom_alu();
      push_alu_range(0, 7);
      run = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (exec_en && pc == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      check("exec_pc7_found", 32'(found), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("midexec_rst_pc", 32'(pc), 32'd0);
      check("midexec_rst_ir", 32'(ir), 32'd0);
      check("midexec_rst_exec_en", 32'(exec_en), 32'd0);
      check("midexec_rst_retired", 32'(retired), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      push(4'd0, rom[0], 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;          // FETCH
      @(posedge clk); #1 run = 1'b0;  // EXEC of address 0
      repeat (3) @(posedge clk);
      #1;
      check("restart_pc", 32'(pc), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #1000000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/k2_sequencer.md
K2_SEQUENCER -- requirements
Module: k2_sequencer

Interface
REQ-001 Parameters: none; all widths fixed by the K2 instruction format (4-bit PC, 8-bit instruction).
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  level; 1 = free-run continuously.
REQ-005 step  input  1  one-cycle pulse; executes exactly one instruction when idle.
REQ-006 inst  input  8  instruction from the combinational program ROM addressed by pc.
REQ-007 carry  input  1  carry flag from the datapath, valid in EXEC.
REQ-008 pc  output  4  program counter; drives the program ROM address.
REQ-009 ir  output  8  instruction register; holds the instruction being executed.
REQ-010 exec_en  output  1  one-cycle strobe; the datapath commits ir when high.
REQ-011 jump_taken  output  1  one-cycle pulse, coincident with exec_en, for a taken J/JC.
REQ-012 illegal  output  1  one-cycle pulse, coincident with exec_en, for an ir[7:6]=11 instruction.
REQ-013 halted  output  1  high while in HALT.
REQ-014 retired  output  8  count of executed instructions, saturating.

Function
REQ-015 Decode: ir[7:6]=00 ALU/load (no PC effect); 01 = JC; 10 = J; 11 = illegal, executed as NOP; target = ir[3:0].
REQ-016 FSM states: IDLE, FETCH, EXEC, HALT.
REQ-017 IDLE: run=1 or step=1 -> FETCH; otherwise stay; pc and ir hold.
REQ-018 FETCH: lasts one cycle; ir <= inst at the end of the cycle; -> EXEC.
REQ-019 EXEC: lasts one cycle; exec_en=1; pc updates at the end of the cycle.
REQ-020 EXEC exit: J to an address equal to the current pc -> HALT.
REQ-021 EXEC exit: otherwise run=1 -> FETCH.
REQ-022 EXEC exit: otherwise -> IDLE.
REQ-023 Next pc: J -> ir[3:0].
REQ-024 Next pc: JC with carry=1 -> ir[3:0].
REQ-025 Next pc: otherwise pc+1, with 15 wrapping to 0.
REQ-026 carry is sampled only in EXEC.
REQ-027 Throughput: one instruction per 2 cycles when free-running.
REQ-028 step while the FSM is not in IDLE: ignored.
REQ-029 step and run both high in IDLE: treated as run.
REQ-030 run dropped during FETCH: the current instruction completes through EXEC, then the FSM goes to IDLE.
REQ-031 HALT: pc and ir hold; exec_en=0; run and step are ignored; only reset exits HALT.
REQ-032 retired increments on every exec_en, including illegal instructions.
REQ-033 retired saturates at 255 and does not wrap.
REQ-034 jump_taken, illegal and exec_en are registered-state decodes and carry no combinational path from the run or step inputs.

Reset
REQ-035 On rst=1, independent of clk: state=IDLE, pc=0, ir=0x00, retired=0, exec_en=0, jump_taken=0, illegal=0, halted=0.
REQ-036 Reset asserted in the middle of FETCH or EXEC aborts the instruction with no exec_en pulse.
REQ-037 After rst deasserts, the first FETCH occurs on the first edge with run=1 or step=1.

Structure
REQ-038 Shared package k2_pkg holds: opcode field constants (OP_ALU=2'b00, OP_JC=2'b01, OP_J=2'b10, OP_ILL=2'b11), the state enum, PC_W=4 and INST_W=8.
REQ-039 One sub-module, k2_next_pc, is combinational.
REQ-040 k2_next_pc inputs: ir, pc, carry.
REQ-041 k2_next_pc outputs: next_pc, taken, self_loop.
REQ-042 The program ROM is external and is not instantiated in k2_sequencer.

Verification
REQ-043 Reset, run=1, ROM holding ALU ops at addresses 0..15 -> pc sequence 0,1,...,15,0 with exec_en every 2nd cycle and retired=16 after 32 cycles.
REQ-044 inst=0x70 (JC 0) at pc=4: carry=1 -> next pc=0 and jump_taken=1; carry=0 -> next pc=5 and jump_taken=0.
REQ-045 inst=0xB2 (J 2) at pc=8 -> pc=2; inst=0xB5 at pc=5 -> halted=1 and pc stays 5 for 20 cycles with run=1.
REQ-046 run=0, one step pulse in IDLE -> exactly one exec_en, pc advances by 1, FSM returns to IDLE; a second step during FETCH is ignored.
REQ-047 inst=0xC3 -> illegal=1 pulse, pc+1, retired increments; 300 executed instructions -> retired=255.
REQ-048 rst asserted mid-EXEC at pc=7 -> immediately pc=0, ir=0x00, exec_en=0; restart with run=1 fetches address 0.
